// File: rtl/adpcm_float_history_pkg.sv
// rtl/adpcm_float_history_pkg.sv - shared float format, defaults and FSM encoding
package adpcm_float_history_pkg;

  localparam int FLOAT_W = 11;
  localparam int DEF_NORM_CYCLES = 15;

  typedef logic [FLOAT_W-1:0] float_t;

  localparam float_t DEF_RESET_FLOAT = 11'h020;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_NORM   = 2'd2,
    ST_COMMIT = 2'd3
  } state_e;

  // 16'h8000 negates to itself, so its magnitude wraps to 0 while the sign stays set.
  function automatic logic [14:0] sr_magnitude(input logic [15:0] sr);
    logic [15:0] neg;
    neg = -sr;
    return sr[15] ? neg[14:0] : sr[14:0];
  endfunction

endpackage

// File: rtl/adpcm_float_history_if.sv
// rtl/adpcm_float_history_if.sv - sample inputs and float history outputs
interface adpcm_float_history_if;
  import adpcm_float_history_pkg::*;

  logic        start_trig;
  logic [15:0] DQ;
  logic [15:0] SR;
  float_t      DQ1, DQ2, DQ3, DQ4, DQ5, DQ6;
  float_t      SR1, SR2;
  logic        busy;
  logic        done;
  logic        overrun;

  modport master (
    output start_trig, DQ, SR,
    input  DQ1, DQ2, DQ3, DQ4, DQ5, DQ6, SR1, SR2, busy, done, overrun
  );

  modport slave (
    input  start_trig, DQ, SR,
    output DQ1, DQ2, DQ3, DQ4, DQ5, DQ6, SR1, SR2, busy, done, overrun
  );

endinterface

// File: rtl/adpcm_norm_serial.sv
// rtl/adpcm_norm_serial.sv - serial left-shift normalizer producing exp/mant
module adpcm_norm_serial (
  input  logic        clk,
  input  logic        reset,
  input  logic        load,
  input  logic [14:0] mag,
  output logic [3:0]  exp,
  output logic [5:0]  mant
);

  logic [14:0] m_q, m_d;
  logic [3:0]  shifts_q, shifts_d;

  always_comb begin
    m_d      = m_q;
    shifts_d = shifts_q;
    if (load) begin
      m_d      = mag;
      shifts_d = 4'd0;
    end else if (!m_q[14] && shifts_q != 4'd15) begin
      m_d      = {m_q[13:0], 1'b0};
      shifts_d = shifts_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      m_q      <= '0;
      shifts_q <= '0;
    end else begin
      m_q      <= m_d;
      shifts_q <= shifts_d;
    end
  end

  // A zero magnitude never normalizes; it maps to the format's fixed zero encoding.
  always_comb begin
    if (m_q == '0) begin
      exp  = 4'd0;
      mant = 6'd32;
    end else begin
      exp  = 4'd15 - shifts_q;
      mant = m_q[14:9];
    end
  end

endmodule

// File: rtl/adpcm_float_history.sv
// rtl/adpcm_float_history.sv - converts DQ/SR to float once per sample and keeps the delay lines
module adpcm_float_history
  import adpcm_float_history_pkg::*;
#(
  parameter float_t RESET_FLOAT = DEF_RESET_FLOAT,
  parameter int     NORM_CYCLES = DEF_NORM_CYCLES
) (
  input  logic                  clk,
  input  logic                  reset,
  adpcm_float_history_if.slave  bus
);

  state_e               state_q, state_d;
  logic [4:0]           norm_cnt_q, norm_cnt_d;
  logic                 start_trig_q, start_trig_d;
  logic                 overrun_q, overrun_d;
  logic                 dq_sign_q, dq_sign_d;
  logic                 sr_sign_q, sr_sign_d;
  logic [5:0][10:0]     dq_hist_q, dq_hist_d;
  logic [1:0][10:0]     sr_hist_q, sr_hist_d;
  logic                 start, norm_load, busy, done;
  logic [3:0]           dq_exp, sr_exp;
  logic [5:0]           dq_mant, sr_mant;

  assign start_trig_d = bus.start_trig;
  assign start        = bus.start_trig & ~start_trig_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      norm_cnt_q   <= '0;
      start_trig_q <= 1'b0;
      overrun_q    <= 1'b0;
      dq_sign_q    <= 1'b0;
      sr_sign_q    <= 1'b0;
      dq_hist_q    <= {6{RESET_FLOAT}};
      sr_hist_q    <= {2{RESET_FLOAT}};
    end else begin
      state_q      <= state_d;
      norm_cnt_q   <= norm_cnt_d;
      start_trig_q <= start_trig_d;
      overrun_q    <= overrun_d;
      dq_sign_q    <= dq_sign_d;
      sr_sign_q    <= sr_sign_d;
      dq_hist_q    <= dq_hist_d;
      sr_hist_q    <= sr_hist_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    norm_cnt_d = norm_cnt_q;
    case (state_q)
      ST_IDLE:   if (start) state_d = ST_LOAD;
      ST_LOAD: begin
        state_d    = ST_NORM;
        norm_cnt_d = '0;
      end
      ST_NORM: begin
        if (norm_cnt_q == 5'(NORM_CYCLES - 1)) state_d = ST_COMMIT;
        else norm_cnt_d = norm_cnt_q + 5'd1;
      end
      ST_COMMIT: state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  // Overrun is registered so no input reaches an output combinationally.
  always_comb begin
    busy      = (state_q == ST_LOAD) || (state_q == ST_NORM);
    done      = (state_q == ST_COMMIT);
    norm_load = (state_q == ST_LOAD);
    overrun_d = start && (state_q != ST_IDLE);
    dq_sign_d = dq_sign_q;
    sr_sign_d = sr_sign_q;
    dq_hist_d = dq_hist_q;
    sr_hist_d = sr_hist_q;
    if (state_q == ST_LOAD) begin
      dq_sign_d = bus.DQ[15];
      sr_sign_d = bus.SR[15];
    end
    if (state_q == ST_COMMIT) begin
      dq_hist_d = {dq_hist_q[4:0], {dq_sign_q, dq_exp, dq_mant}};
      sr_hist_d = {sr_hist_q[0], {sr_sign_q, sr_exp, sr_mant}};
    end
  end

  adpcm_norm_serial u_norm_dq (
    .clk   (clk),
    .reset (reset),
    .load  (norm_load),
    .mag   (bus.DQ[14:0]),
    .exp   (dq_exp),
    .mant  (dq_mant)
  );

  adpcm_norm_serial u_norm_sr (
    .clk   (clk),
    .reset (reset),
    .load  (norm_load),
    .mag   (sr_magnitude(bus.SR)),
    .exp   (sr_exp),
    .mant  (sr_mant)
  );

  assign bus.DQ1     = dq_hist_q[0];
  assign bus.DQ2     = dq_hist_q[1];
  assign bus.DQ3     = dq_hist_q[2];
  assign bus.DQ4     = dq_hist_q[3];
  assign bus.DQ5     = dq_hist_q[4];
  assign bus.DQ6     = dq_hist_q[5];
  assign bus.SR1     = sr_hist_q[0];
  assign bus.SR2     = sr_hist_q[1];
  assign bus.busy    = busy;
  assign bus.done    = done;
  assign bus.overrun = overrun_q;

endmodule

// File: tb/tb_adpcm_float_history.sv
// tb/tb_adpcm_float_history.sv - scoreboard bench with hand-computed float vectors
module tb_adpcm_float_history;
  import adpcm_float_history_pkg::*;

  typedef struct packed {
    logic [5:0][10:0] dq;
    logic [1:0][10:0] sr;
    logic [31:0]      cyc;
  } exp_t;

  logic clk = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  adpcm_float_history_if bus();

  adpcm_float_history dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  int ovr_cnt = 0;
  int done_cnt = 0;
  exp_t expq[$];
  exp_t mon_e;
  logic [5:0][10:0] sh_dq;
  logic [1:0][10:0] sh_sr;
  logic [5:0][10:0] out_dq;
  logic [1:0][10:0] out_sr;

  assign out_dq = {bus.DQ6, bus.DQ5, bus.DQ4, bus.DQ3, bus.DQ2, bus.DQ1};
  assign out_sr = {bus.SR2, bus.SR1};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s: actual=%0h required=%0h", name, act, req);
    end
  endtask

  task automatic check_history(input string tag, input logic [5:0][10:0] dq, input logic [1:0][10:0] sr);
    for (int i = 0; i < 6; i++) check($sformatf("%s_DQ%0d", tag, i + 1), 32'(out_dq[i]), 32'(dq[i]));
    for (int i = 0; i < 2; i++) check($sformatf("%s_SR%0d", tag, i + 1), 32'(out_sr[i]), 32'(sr[i]));
  endtask

  // Monitor: every done pulse must match the next queued expectation.
  always @(negedge clk) begin
    if (!reset && bus.overrun) ovr_cnt++;
    if (!reset && bus.done) begin
      done_cnt++;
      if (expq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_done: actual=done at cycle %0d required=no commit", cyc);
      end else begin
        mon_e = expq.pop_front();
        check("done_latency", 32'(cyc), mon_e.cyc);
        @(posedge clk);
        #1;
        check_history("commit", mon_e.dq, mon_e.sr);
      end
    end
  end

  task automatic push_expect(input logic [10:0] fdq, input logic [10:0] fsr);
    exp_t e;
    sh_dq = {sh_dq[4:0], fdq};
    sh_sr = {sh_sr[0], fsr};
    e.dq  = sh_dq;
    e.sr  = sh_sr;
    e.cyc = 32'(cyc + 17);
    expq.push_back(e);
  endtask

  // One 34-clock start_trig period; inputs are scrambled after LOAD to prove they are latched.
  task automatic sample(input logic [15:0] dq, input logic [15:0] sr,
                        input logic [10:0] fdq, input logic [10:0] fsr);
    @(negedge clk);
    bus.DQ = dq;
    bus.SR = sr;
    bus.start_trig = 1'b1;
    push_expect(fdq, fsr);
    repeat (3) @(negedge clk);
    bus.DQ = ~dq;
    bus.SR = ~sr;
    repeat (14) @(negedge clk);
    bus.start_trig = 1'b0;
    repeat (17) @(negedge clk);
  endtask

  initial begin
    int ovr_before;
    int done_before;
    sh_dq = {6{11'h020}};
    sh_sr = {2{11'h020}};
    bus.start_trig = 1'b0;
    bus.DQ = 16'h0000;
    bus.SR = 16'h0000;
    reset = 1'b1;
    repeat (3) @(negedge clk);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    check_history("reset", sh_dq, sh_sr);
    check("reset_busy", 32'(bus.busy), 32'd0);
    check("reset_done", 32'(bus.done), 32'd0);
    check("reset_overrun", 32'(bus.overrun), 32'd0);

    sample(16'h0000, 16'h0100, 11'h020, 11'h260);
    sample(16'h8001, 16'hFFFF, 11'h460, 11'h460);
    sample(16'h7FFF, 16'h8000, 11'h3FF, 11'h420);
    sample(16'h0004, 16'h0003, 11'h0E0, 11'h0B0);
    sample(16'h0123, 16'hFF00, 11'h264, 11'h660);
    sample(16'h8400, 16'h7FFF, 11'h6E0, 11'h3FF);
    sample(16'h4000, 16'h0000, 11'h3E0, 11'h020);

    // Second start edge five clocks into a conversion.
    ovr_before = ovr_cnt;
    @(negedge clk);
    bus.DQ = 16'h0020;
    bus.SR = 16'h0040;
    bus.start_trig = 1'b1;
    push_expect(11'h1A0, 11'h1E0);
    repeat (3) @(negedge clk);
    bus.start_trig = 1'b0;
    repeat (2) @(negedge clk);
    bus.start_trig = 1'b1;
    repeat (12) @(negedge clk);
    bus.start_trig = 1'b0;
    repeat (17) @(negedge clk);
    check("overrun_pulses", 32'(ovr_cnt - ovr_before), 32'd1);

    // Reset during NORM cycle 8 aborts the conversion.
    done_before = done_cnt;
    @(negedge clk);
    bus.DQ = 16'h1234;
    bus.SR = 16'h4321;
    bus.start_trig = 1'b1;
    repeat (9) @(negedge clk);
    check("busy_mid_norm", 32'(bus.busy), 32'd1);
    reset = 1'b1;
    bus.start_trig = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    sh_dq = {6{11'h020}};
    sh_sr = {2{11'h020}};
    @(negedge clk);
    check_history("abort", sh_dq, sh_sr);
    check("abort_busy", 32'(bus.busy), 32'd0);
    check("abort_state", 32'(dut.state_q), 32'(ST_IDLE));
    repeat (20) @(negedge clk);
    check("abort_no_done", 32'(done_cnt - done_before), 32'd0);

    sample(16'h0001, 16'h8000, 11'h060, 11'h420);

    repeat (5) @(negedge clk);
    check("queue_drained", 32'(expq.size()), 32'd0);
    check("total_commits", 32'(done_cnt), 32'd9);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
